// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: sequential 8x8 unsigned shift-and-add multiplier.
// Takes one partial-product step per clock and owns the 16-bit product register.
// Optional build macro MULT8_EARLY_TERM_EN ends the iteration as soon as
// no multiplier bits remain; a zero multiplier skips ITER entirely.
module mult8_seq_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] product_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [15:0] mcand_q;
  logic [15:0] acc_q;
  logic [7:0]  mplier_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] acc_d;
  logic [7:0]  mplier_d;
  logic        last_step_d;

  // Next partial sum, shifted multiplier and end-of-iteration decision.
  always_comb begin
    acc_d       = acc_q;
    mplier_d    = mplier_q >> 1;
    last_step_d = (cnt_q == 3'd7);
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
`ifdef MULT8_EARLY_TERM_EN
    if (mplier_d == '0) begin
      last_step_d = 1'b1;
    end
`endif
  end

  // Controller FSM with registered busy/done strobes and datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start_in) begin
            mcand_q  <= {8'h00, a_in};
            mplier_q <= b_in;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef MULT8_EARLY_TERM_EN
            if (b_in == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ITER;
              busy_q  <= 1'b1;
            end
`else
            state_q <= S_ITER;
            busy_q  <= 1'b1;
`endif
          end
        end
        S_ITER: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 3'd1;
          if (last_step_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign product_out = acc_q;

endmodule
